// File: rtl/data_memory_responder_if.sv
// Request/response channel between the memory-access stage (master) and the data memory (slave).
interface data_memory_responder_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [XLEN-1:0] req_addr;
  logic [1:0]      req_size;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: one outstanding load/store, lane-selected stores,
// right-aligned load data, configurable wait states and error responses.
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | wait-state countdown; access performed when counter reaches 0
// RESP  | response presented until resp_ready
module data_memory_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  data_memory_responder_if.slave mem,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic            write_q, err_q, resp_err_q;
  logic [1:0]      size_q, lane_q;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] wdata_q, rdata_q;
  logic            accept, req_err, access;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata_sh, load_word;

  logic [XLEN-1:0] mem_array [DEPTH_WORDS];

  assign accept = mem.req_valid && (state == IDLE);
  assign access = (state == WAIT) && (cnt == 4'd0);

  always_comb begin
    req_err = 1'b0;
    if (mem.req_size == 2'b11)                               req_err = 1'b1;
    if ((mem.req_size == 2'b01) && mem.req_addr[0])          req_err = 1'b1;
    if ((mem.req_size == 2'b10) && (|mem.req_addr[1:0]))     req_err = 1'b1;
    if (|mem.req_addr[XLEN-1:AW+2])                          req_err = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Errors also pass through WAIT (with a zero count) so every response
  // arrives at least one cycle after acceptance.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (mem.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem.req_ready  = (state == IDLE);
    mem.resp_valid = (state == RESP);
    mem.resp_rdata = rdata_q;
    mem.resp_error = resp_err_q;
    busy           = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        write_q <= mem.req_write;
        err_q   <= req_err;
        size_q  <= mem.req_size;
        lane_q  <= mem.req_addr[1:0];
        idx_q   <= mem.req_addr[AW+1:2];
        wdata_q <= mem.req_wdata;
        cnt     <= req_err ? 4'd0 : 4'(WAIT_STATES);
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (access) begin
        rdata_q    <= (err_q || write_q) ? '0 : load_word;
        resp_err_q <= err_q;
      end
    end
  end

  always_comb begin
    case (size_q)
      2'b00:   be = 4'b0001 << lane_q;
      2'b01:   be = 4'b0011 << {lane_q[1], 1'b0};
      default: be = 4'b1111;
    endcase
  end

  assign wdata_sh  = wdata_q << {lane_q, 3'b000};
  assign load_word = mem_array[idx_q] >> {lane_q, 3'b000};

  // Array is deliberately not reset; a reset during WAIT blocks the write via state.
  always_ff @(posedge clk) begin
    if (access && write_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_array[idx_q][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end
endmodule
